// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encoding, command layout.
package alu_pkg;

  localparam int unsigned OP_W       = 3;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_TAG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_OR   = 3'd4;
  localparam logic [OP_W-1:0] OP_NAND = 3'd5;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Command payload for the default configuration, MSB first: {op, a, b, tag}
  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_TAG_W-1:0]  tag;
  } alu_cmd_t;

  localparam int unsigned CMD_W = $bits(alu_cmd_t);

  // Only ADD and SUB produce a meaningful carry; other ops leave it stale
  function automatic logic op_has_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty distinction.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Next storage and pointer values; pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: queues tagged commands, drives the ALU one at a
// time through registered inputs and returns responses in command order.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TAG_W      = DEF_TAG_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [OP_W-1:0]               cmd_op,
  input  logic [DATA_W-1:0]             cmd_a,
  input  logic [DATA_W-1:0]             cmd_b,
  input  logic [TAG_W-1:0]              cmd_tag,
  output logic [OP_W-1:0]               alu_operation,
  output logic [DATA_W-1:0]             alu_operand_A,
  output logic [DATA_W-1:0]             alu_operand_B,
  input  logic [2*DATA_W-1:0]           alu_result,
  input  logic                          alu_carry_flag,
  input  logic                          alu_zero_flag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2*DATA_W-1:0]           rsp_result,
  output logic                          rsp_carry,
  output logic                          rsp_zero,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned ENT_W = OP_W + 2 * DATA_W + TAG_W;

  seq_state_e          state_q, state_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]    fifo_wdata, fifo_rdata;
  logic [OP_W-1:0]     head_op;
  logic [DATA_W-1:0]   head_a, head_b;
  logic [TAG_W-1:0]    head_tag;

  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue/capture/response sequencing and next register values
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_op_d = head_op;
          alu_a_d  = head_a;
          alu_b_d  = head_b;
          tag_d    = head_tag;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_carry_d  = op_has_carry(alu_op_q) ? alu_carry_flag : 1'b0;
        rsp_zero_d   = alu_zero_flag;
        rsp_tag_d    = tag_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            tag_d    = head_tag;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, ALU-input and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign alu_operation = alu_op_q;
  assign alu_operand_A = alu_a_q;
  assign alu_operand_B = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_carry     = rsp_carry_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_tag       = rsp_tag_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_operand_A, alu_operand_B;
  logic [15:0] alu_result;
  logic        alu_carry_flag, alu_zero_flag;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [2:0]  fifo_count;

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .DATA_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operation(alu_operation), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
    .alu_result(alu_result), .alu_carry_flag(alu_carry_flag), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU; carry reads as a stale 1 for non-arith ops
  always_comb begin
    alu_result     = 16'h0000;
    alu_carry_flag = 1'b1;
    case (alu_operation)
      3'd0: begin alu_result = 16'(alu_operand_A) + 16'(alu_operand_B); alu_carry_flag = alu_result[8]; end
      3'd1: begin alu_result = 16'(alu_operand_A) - 16'(alu_operand_B); alu_carry_flag = (alu_operand_A < alu_operand_B); end
      3'd2: alu_result = 16'(alu_operand_A) * 16'(alu_operand_B);
      3'd3: alu_result = {8'h00, alu_operand_A & alu_operand_B};
      3'd4: alu_result = {8'h00, alu_operand_A | alu_operand_B};
      3'd5: alu_result = {8'h00, ~(alu_operand_A & alu_operand_B)};
      3'd6: alu_result = {8'h00, ~(alu_operand_A | alu_operand_B)};
      default: alu_result = {8'h00, alu_operand_A ^ alu_operand_B};
    endcase
    alu_zero_flag = (alu_result == 16'h0000);
  end

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] res;
    logic        c;
    logic        z;
  } rsp_t;

  rsp_t sb[$];
  rsp_t last_rsp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  bit   hold_v = 1'b0;
  logic [21:0] held;

  // Expected response computed from the opcode's arithmetic meaning
  function automatic rsp_t model(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] tag);
    rsp_t m;
    int ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin r = ia - ib; c = (ia < ib); end
      3'd2: r = ia * ib;
      3'd3: r = ia & ib;
      3'd4: r = ia | ib;
      3'd5: r = (~(ia & ib)) & 255;
      3'd6: r = (~(ia | ib)) & 255;
      default: r = ia ^ ib;
    endcase
    m.tag = tag;
    m.res = 16'(r);
    m.c   = c;
    m.z   = (m.res == 16'h0000);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accepts push expectations, responses pop and compare
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      check("busy_vs_inflight", 32'(busy), 32'(sb.size() != 0));
      check("cmd_ready_vs_count", 32'(cmd_ready), 32'(fifo_count < 3'(DEPTH)));
      if (rsp_valid) begin
        if (hold_v) check("rsp_stable_stalled", 32'({rsp_tag, rsp_carry, rsp_zero, rsp_result}), 32'(held));
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_tag), 32'hFFFF_FFFF);
          end else begin
            rsp_t e;
            e = sb.pop_front();
            check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_carry", 32'(rsp_carry), 32'(e.c));
            check("rsp_zero", 32'(rsp_zero), 32'(e.z));
          end
          last_rsp.tag = rsp_tag;
          last_rsp.res = rsp_result;
          last_rsp.c   = rsp_carry;
          last_rsp.z   = rsp_zero;
          rsp_cnt++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = {rsp_tag, rsp_carry, rsp_zero, rsp_result};
        end
      end else begin
        hold_v = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        sb.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic try_send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag, input int max_cyc, output bit ok);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    ok        = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag);
    bit ok;
    try_send(op, a, b, tag, 50, ok);
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int i;
    rsp_ready = 1'b1;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 500) begin
      tick();
      i++;
    end
    check("drain_done_in_time", 32'(i < 500), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tagname, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tagname, "_busy"}, 32'(busy), 32'd0);
    check({tagname, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tagname, "_alu_in"}, 32'({alu_operation, alu_operand_A, alu_operand_B}), 32'd0);
    check({tagname, "_rsp_fields"}, 32'({rsp_tag, rsp_carry, rsp_zero, rsp_result}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, acc0, rsp0, acc_t5;
    bit  ok;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_tag   = 4'h0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("por_cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    tick();

    // ADD with carry out and exact latency
    rsp_ready = 1'b1;
    send(3'd0, 8'hFF, 8'h01, 4'd3);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check("latency_cycles", 32'(lat), 32'd3);
    check("add_result", 32'(rsp_result), 32'h0100);
    check("add_carry", 32'(rsp_carry), 32'd1);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_tag", 32'(rsp_tag), 32'd3);
    tick();
    drain();

    // SUB borrow, MUL full-width product
    send(3'd1, 8'h05, 8'h07, 4'd1);
    drain();
    check("sub_result", 32'(last_rsp.res), 32'hFFFE);
    check("sub_carry", 32'(last_rsp.c), 32'd1);
    send(3'd2, 8'hFF, 8'hFF, 4'd2);
    drain();
    check("mul_result", 32'(last_rsp.res), 32'hFE01);
    check("mul_carry", 32'(last_rsp.c), 32'd0);
    check("mul_zero", 32'(last_rsp.z), 32'd0);

    // ADD carry must not leak into a following AND
    send(3'd0, 8'hFF, 8'h01, 4'd4);
    send(3'd3, 8'h0F, 8'hF0, 4'd5);
    drain();
    check("and_tag", 32'(last_rsp.tag), 32'd5);
    check("and_result", 32'(last_rsp.res), 32'h0000);
    check("and_zero", 32'(last_rsp.z), 32'd1);
    check("and_carry", 32'(last_rsp.c), 32'd0);

    // Backpressure: only FIFO_DEPTH+1 commands fit
    rsp_ready = 1'b0;
    rsp0      = rsp_cnt;
    acc_t5    = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i + 8), 8, ok);
      if (ok) acc_t5++;
    end
    check("bp_accepted", 32'(acc_t5), 32'd5);
    @(negedge clk);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    drain();
    check("bp_responses", 32'(rsp_cnt - rsp0), 32'd5);

    // Asynchronous reset while in RESP with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i));
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    check("pre_reset_fifo_count", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    tick();

    // Saturating stream then random traffic across many pointer wraps
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i));
    end
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    drain();
    check("stream_no_loss", 32'(rsp_cnt - rsp0), 32'(acc_cnt - acc0));
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
